stage_mem_lsu: RTL

- Parametrised memory pipeline stage for the br32 core: sits between EX and WB.
- Registers the EX results and performs the data-memory access for loads and stores over a valid/ready request and response interface.
- Stalls upstream while an access is outstanding.
- Handles byte-lane alignment, byte enables, and load sign/zero extension; generalised to XLEN 32 or 64.

---
 rtl/stage_mem_lsu_if.sv | 24 ++
 rtl/stage_mem_lsu.sv | 133 +++++++++++++
 2 files changed

// File: rtl/stage_mem_lsu_if.sv
// Data-memory request/response bundle between the MEM stage (master) and memory (slave).
interface stage_mem_lsu_if #(
  parameter int XLEN = 32
);
  localparam int BE_W = XLEN / 8;

  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic [XLEN-1:0]   dmem_req_addr;
  logic              dmem_req_we;
  logic [BE_W-1:0]   dmem_req_be;
  logic [XLEN-1:0]   dmem_req_wdata;
  logic              dmem_resp_valid;
  logic [XLEN-1:0]   dmem_resp_rdata;

  modport master (
    output dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_be, dmem_req_wdata,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
  );
  modport slave (
    input  dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_be, dmem_req_wdata,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
  );
endinterface

// File: rtl/stage_mem_lsu.sv
// br32 MEM stage: registers EX results and performs one data-memory access per load/store.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses trap instead of being force-aligned.
module stage_mem_lsu #(
  parameter  int XLEN   = 32,
  parameter  int RIDX_W = 5,
  localparam int BE_W   = XLEN / 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic [XLEN-1:0]     ex_pc,
  input  logic [XLEN-1:0]     ex_nextpc,
  input  logic [XLEN-1:0]     ex_alu_res,
  input  logic [XLEN-1:0]     ex_mem_data,
  input  logic [RIDX_W-1:0]   ex_rd,
  input  logic                ex_w_rd,
  input  logic                ex_link,
  input  logic                ex_mem_rd,
  input  logic                ex_mem_wr,
  input  logic [1:0]          ex_mem_size,
  input  logic                ex_mem_unsigned,
  output logic                stall,
  stage_mem_lsu_if.master     dmem,
  output logic [XLEN-1:0]     out_pc,
  output logic [XLEN-1:0]     out_res,
  output logic [RIDX_W-1:0]   out_rd,
  output logic                out_w_rd,
  output logic                out_bubble,
  output logic                out_misalign
);
  localparam int LO_W = $clog2(BE_W);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  typedef struct packed {
    logic [XLEN-1:0]   pc, nextpc, alu, mdata;
    logic [RIDX_W-1:0] rd;
    logic              w_rd, link, mem_rd, mem_wr;
    logic [1:0]        size;
    logic              uns, bubble;
  } ex_t;

  function automatic logic [LO_W-1:0] size_mask(input logic [1:0] sz);
    logic [3:0] m;
    m = (4'd1 << sz) - 4'd1;
    return m[LO_W-1:0];
  endfunction

  ex_t             ex_q, ex_d;
  state_t          state_q, state_d;
  logic [XLEN-1:0] ld_q, ld_d;
  logic [LO_W-1:0] lo;
  logic            ex_ok;
  logic [XLEN-1:0] shifted, ext;
  logic [BE_W-1:0] be;
  logic            sbit;
  int              nb, lo_i;

  assign stall = (state_q == REQ) || (state_q == WAIT);
  // Offset with the size-alignment bits cleared; identical to the raw offset for aligned accesses.
  assign lo    = ex_q.alu[LO_W-1:0] & ~size_mask(ex_q.size);

`ifdef LSU_MISALIGN_TRAP_EN
  assign ex_ok        = (ex_alu_res[LO_W-1:0] & size_mask(ex_mem_size)) == '0;
  assign out_misalign = !ex_q.bubble && (ex_q.mem_rd || ex_q.mem_wr) &&
                        ((ex_q.alu[LO_W-1:0] & size_mask(ex_q.size)) != '0);
`else
  assign ex_ok        = 1'b1;
  assign out_misalign = 1'b0;
`endif

  // Byte-lane steering: request enables and load extraction.
  always_comb begin
    nb = 1 << ex_q.size;
    if (nb > BE_W) nb = BE_W;
    lo_i    = int'(lo);
    shifted = dmem.dmem_resp_rdata >> {lo, 3'b000};
    be      = '0;
    ext     = '0;
    for (int i = 0; i < BE_W; i++) be[i] = (i >= lo_i) && (i < lo_i + nb);
    case (ex_q.size)
      2'd0:    sbit = shifted[7];
      2'd1:    sbit = shifted[15];
      2'd2:    sbit = shifted[31];
      default: sbit = shifted[XLEN-1];
    endcase
    for (int i = 0; i < XLEN; i++) ext[i] = (i < 8 * nb) ? shifted[i] : (sbit && !ex_q.uns);
  end

  always_comb begin
    state_d = state_q;
    ex_d    = ex_q;
    ld_d    = ld_q;
    case (state_q)
      REQ:  if (dmem.dmem_req_ready) state_d = ex_q.mem_wr ? DONE : WAIT;
      WAIT: if (dmem.dmem_resp_valid) begin
        ld_d    = ext;
        state_d = DONE;
      end
      default: begin
        ex_d = '{pc: ex_pc, nextpc: ex_nextpc, alu: ex_alu_res, mdata: ex_mem_data,
                 rd: ex_rd, w_rd: ex_w_rd, link: ex_link, mem_rd: ex_mem_rd,
                 mem_wr: ex_mem_wr, size: ex_mem_size, uns: ex_mem_unsigned,
                 bubble: !ex_valid};
        state_d = (ex_valid && (ex_mem_rd || ex_mem_wr) && ex_ok) ? REQ : IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ex_q         <= '0;
      ex_q.bubble  <= 1'b1;
      ld_q         <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      ld_q    <= ld_d;
    end
  end

  assign dmem.dmem_req_valid = (state_q == REQ);
  assign dmem.dmem_req_we    = ex_q.mem_wr;
  assign dmem.dmem_req_addr  = {ex_q.alu[XLEN-1:LO_W], lo};
  assign dmem.dmem_req_be    = be;
  assign dmem.dmem_req_wdata = ex_q.mdata << {lo, 3'b000};

  assign out_bubble = ex_q.bubble || stall;
  assign out_w_rd   = ex_q.w_rd && !out_bubble && !out_misalign;
  assign out_res    = ex_q.link ? ex_q.nextpc : (ex_q.mem_rd ? ld_q : ex_q.alu);
  assign out_pc     = ex_q.pc;
  assign out_rd     = ex_q.rd;
endmodule
